// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage in front of the CPU core.
// The byte-wide program ROM is read two bytes per instruction (even byte
// first). Each {opcode1, opcode2} pair and its address go into a small
// prefetch FIFO, and the core takes them with a valid/ready handshake.
// Fetch runs sequentially by +2. A pc_load pulse redirects it.
//
// Ports:
//   clk          clock, all state on posedge
//   reset        asynchronous, active-low reset
//   pc_load      redirect pulse from the core
//   pc_in        redirect target (bit 0 forced to 0)
//   rom_rd       ROM read strobe
//   rom_addr     ROM byte address
//   rom_data     ROM read data, valid one cycle after rom_rd
//   instr_valid  FIFO head holds a complete instruction
//   instr_ready  core accepts the head this cycle
//   opcode1      head byte from the even address
//   opcode2      head byte from the odd address
//   instr_addr   address of opcode1 of the head
//   busy         a ROM read is in flight
module instr_fetch #(
  parameter int         DEPTH      = 2,
  parameter logic [7:0] RESET_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pc_load,
  input  logic [7:0] pc_in,
  output logic       rom_rd,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] opcode1,
  output logic [7:0] opcode2,
  output logic [7:0] instr_addr,
  output logic       busy
);

  localparam logic [2:0] DEPTH_W  = 3'(DEPTH);
  localparam logic [1:0] PTR_LAST = 2'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RD0, RD1, WAIT} state_t;

  state_t     state_reg, state_next;
  logic [7:0] fptr_reg;
  logic [7:0] hi_byte_reg;
  logic       lo_pending_reg;
  logic [1:0] wr_ptr_reg, rd_ptr_reg;
  logic [2:0] count_reg;

  // The storage is sized for the largest legal DEPTH. Only DEPTH entries are used.
  logic [7:0] mem_hi   [4];
  logic [7:0] mem_lo   [4];
  logic [7:0] mem_addr [4];

  logic       push, pop, inflight, room;
  logic [2:0] count_post_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign instr_valid = (count_reg != 3'd0);
  // A redirect cancels both the completing push and any pop in the same cycle.
  assign push = lo_pending_reg & ~pc_load;
  assign pop  = instr_valid & instr_ready & ~pc_load;

  // An instruction is in flight from RD1 until its push cycle, including the
  // push cycle itself. The FIFO count excludes it until it lands.
  assign inflight       = (state_reg == RD1) | lo_pending_reg;
  assign count_post_pop = count_reg - {2'b00, pop};
  assign room           = (count_post_pop + {2'b00, inflight}) < DEPTH_W;

  assign busy = (state_reg == RD0) | (state_reg == RD1) | lo_pending_reg;

  assign opcode1    = instr_valid ? mem_hi[rd_ptr_reg]   : 8'h00;
  assign opcode2    = instr_valid ? mem_lo[rd_ptr_reg]   : 8'h00;
  assign instr_addr = instr_valid ? mem_addr[rd_ptr_reg] : 8'h00;

  always_comb begin
    state_next = state_reg;
    rom_rd     = 1'b0;
    rom_addr   = 8'h00;
    case (state_reg)
      IDLE: state_next = RD0;
      RD0: begin
        rom_rd = 1'b1;
        // fptr advances at the end of a push cycle. When RD0 overlaps that
        // push, use the already-advanced address.
        rom_addr   = lo_pending_reg ? fptr_reg + 8'd2 : fptr_reg;
        state_next = RD1;
      end
      RD1: begin
        rom_rd     = 1'b1;
        rom_addr   = fptr_reg + 8'd1;
        state_next = room ? RD0 : WAIT;
      end
      WAIT:    state_next = room ? RD0 : WAIT;
      default: state_next = IDLE;
    endcase
    if (pc_load) state_next = RD0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      fptr_reg       <= RESET_ADDR;
      hi_byte_reg    <= 8'h00;
      lo_pending_reg <= 1'b0;
      wr_ptr_reg     <= 2'd0;
      rd_ptr_reg     <= 2'd0;
      count_reg      <= 3'd0;
    end else begin
      state_reg <= state_next;
      if (pc_load) begin
        fptr_reg       <= pc_in & 8'hFE;
        hi_byte_reg    <= 8'h00;
        lo_pending_reg <= 1'b0;
        wr_ptr_reg     <= 2'd0;
        rd_ptr_reg     <= 2'd0;
        count_reg      <= 3'd0;
      end else begin
        if (state_reg == RD1) hi_byte_reg <= rom_data;
        lo_pending_reg <= (state_reg == RD1);
        if (lo_pending_reg) fptr_reg <= fptr_reg + 8'd2;
        if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        count_reg <= count_reg + {2'b00, push} - {2'b00, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_hi[wr_ptr_reg]   <= hi_byte_reg;
      mem_lo[wr_ptr_reg]   <= rom_data;
      mem_addr[wr_ptr_reg] <= fptr_reg;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch (DEPTH=2). A behavioural ROM answers reads one cycle
// later. A queue holds the expected instruction stream, and every accepted
// handshake is checked against it.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       reset, pc_load, instr_ready;
  logic [7:0] pc_in, rom_addr, rom_data, opcode1, opcode2, instr_addr;
  logic       rom_rd, instr_valid, busy;

  instr_fetch #(.DEPTH(2), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .reset(reset), .pc_load(pc_load), .pc_in(pc_in),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode1(opcode1), .opcode2(opcode2), .instr_addr(instr_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [256];
  always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [7:0] op1;
    logic [7:0] op2;
    logic [7:0] addr;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec    = 0;
  int   n_bad    = 0;
  int   n_popped = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream: n sequential instructions starting at a (wraps mod 256).
  task automatic start_expect(input logic [7:0] a, input int n);
    logic [7:0] p;
    exp_t e;
    p = a;
    q.delete();
    for (int i = 0; i < n; i++) begin
      e.op1  = rom[p];
      e.op2  = rom[8'(p + 8'd1)];
      e.addr = p;
      q.push_back(e);
      p = p + 8'd2;
    end
  endtask

  // Wait for n more accepted instructions. ready_mode 0 means always ready,
  // 1 means one cycle in three, and 2 means random.
  task automatic wait_pops(input int n, input int ready_mode, input int budget);
    int target;
    int cyc;
    target = n_popped + n;
    cyc = 0;
    while (n_popped < target && cyc < budget) begin
      case (ready_mode)
        0:       instr_ready = 1'b1;
        1:       instr_ready = (cyc % 3 == 0);
        default: instr_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      cyc++;
    end
    chk("pop_budget", 32'(n_popped >= target), 32'd1);
  endtask

  // Scoreboard: every accepted instruction must match the next expected one.
  always @(negedge clk) begin
    if (reset && !pc_load && instr_valid && instr_ready) begin
      n_popped++;
      if (q.size() == 0) begin
        chk("extra_pop", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("pop_data", 32'({opcode1, opcode2, instr_addr}), 32'(mon_e));
      end
    end
  end

  typedef struct {
    logic [7:0] pc;
    logic [7:0] first_addr;
    int         n;
    int         ready_mode;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h33, 8'h32, 4, 0};
    vecs[1] = '{8'h80, 8'h80, 5, 1};
    vecs[2] = '{8'hFD, 8'hFC, 4, 2};
    vecs[3] = '{8'h07, 8'h06, 3, 2};
    vecs[4] = '{8'hC9, 8'hC8, 4, 1};

    for (int i = 0; i < 256; i++) rom[i] = 8'(i * 37 + 11);
    rom[0] = 8'h10; rom[1] = 8'h2A; rom[2] = 8'h20;
    rom[3] = 8'h3B; rom[4] = 8'h81; rom[5] = 8'h4C;

    reset = 1'b0; pc_load = 1'b0; pc_in = 8'h00; instr_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_rom", 32'({rom_rd, rom_addr}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_head", 32'({opcode1, opcode2, instr_addr}), 32'd0);

    // Reset release: sequential fetch, 3-cycle latency, one pop per 2 cycles.
    start_expect(8'h00, 40);
    instr_ready = 1'b1;
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("seq_addr", 32'({rom_rd, rom_addr}), 32'({1'b1, 8'(k - 1)}));
      chk("seq_valid", 32'(instr_valid), 32'(k == 4 || k == 6));
    end
    chk("seq_busy", 32'(busy), 32'd1);
    wait_pops(1, 0, 10);

    // Stall: two instructions buffered, WAIT holds rom_rd low, head held.
    instr_ready = 1'b0; pc_load = 1'b1; pc_in = 8'h00;
    start_expect(8'h00, 40);
    tick();
    pc_load = 1'b0;
    chk("stall_first", 32'({rom_rd, rom_addr}), 32'h100);
    for (int j = 2; j <= 10; j++) begin
      tick();
      if (j >= 5) chk("stall_rd", 32'(rom_rd), 32'd0);
      if (j >= 4) chk("stall_head", 32'({instr_valid, opcode1, opcode2, instr_addr}), 32'h1102A00);
    end
    chk("stall_busy", 32'(busy), 32'd0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("resume_addr", 32'({rom_rd, rom_addr}), 32'h104);
    chk("resume_head", 32'({opcode1, opcode2, instr_addr}), 32'h203B02);
    tick();
    chk("resume_rd1", 32'({rom_rd, rom_addr}), 32'h105);
    tick();
    chk("lo_pend_rd", 32'({rom_rd, busy}), 32'h1);
    // A pop and a push in the same cycle with one entry held.
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("pp_head", 32'({instr_valid, opcode1, opcode2, instr_addr}), 32'h1814C04);
    chk("pp_next", 32'({rom_rd, rom_addr}), 32'h106);
    wait_pops(4, 0, 30);

    // Redirect during RD1: the in-flight byte is dropped and the FIFO is cleared.
    instr_ready = 1'b1;
    begin
      int b;
      b = 0;
      while (!(rom_rd && rom_addr[0]) && b < 10) begin
        tick();
        b++;
      end
      chk("find_rd1", 32'(rom_rd && rom_addr[0]), 32'd1);
    end
    pc_load = 1'b1; pc_in = 8'h41;
    start_expect(8'h40, 40);
    tick();
    pc_load = 1'b0;
    chk("redir_valid", 32'(instr_valid), 32'd0);
    chk("redir_a0", 32'({rom_rd, rom_addr}), 32'h140);
    tick();
    chk("redir_a1", 32'({rom_rd, rom_addr}), 32'h141);
    wait_pops(2, 0, 20);

    // Wraparound from FE to 00.
    pc_load = 1'b1; pc_in = 8'hFE;
    start_expect(8'hFE, 40);
    tick();
    pc_load = 1'b0;
    chk("wrap_a0", 32'({rom_rd, rom_addr}), 32'h1FE);
    tick();
    chk("wrap_a1", 32'({rom_rd, rom_addr}), 32'h1FF);
    tick();
    chk("wrap_a2", 32'({rom_rd, rom_addr}), 32'h100);
    tick();
    chk("wrap_a3", 32'({rom_rd, rom_addr}), 32'h101);
    wait_pops(2, 0, 20);

    // Reset asserted during lo_pending with one entry buffered.
    instr_ready = 1'b0; pc_load = 1'b1; pc_in = 8'h10;
    q.delete();
    tick();
    pc_load = 1'b0;
    repeat (4) tick();
    chk("pre_rst", 32'({busy, instr_valid, rom_rd}), 32'h6);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'({instr_valid, busy, rom_rd}), 32'd0);
    chk("mid_rst_head", 32'({opcode1, opcode2, instr_addr}), 32'd0);
    start_expect(8'h00, 40);
    tick();
    reset = 1'b1; instr_ready = 1'b1;
    tick();
    chk("rst_restart", 32'({rom_rd, rom_addr}), 32'h100);
    wait_pops(3, 0, 20);

    // Table-driven redirects under different ready patterns.
    for (int v = 0; v < 5; v++) begin
      pc_load = 1'b1; pc_in = vecs[v].pc;
      start_expect(vecs[v].first_addr, vecs[v].n + 40);
      tick();
      pc_load = 1'b0;
      chk("vec_first", 32'({rom_rd, rom_addr}), 32'({1'b1, vecs[v].first_addr}));
      wait_pops(vecs[v].n, vecs[v].ready_mode, 300);
    end

    instr_ready = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the CPU core.
- Reads the byte-wide program ROM two bytes per instruction and assembles each {opcode1, opcode2} pair.
- Buffers assembled instructions in a small prefetch FIFO and hands them to the core with a valid/ready handshake.
- Follows the core's PC: sequential fetch by +2, redirected on branch/reset via pc_load.

Parameters:
DEPTH, 2, prefetch FIFO entries (instructions); legal 1..4
RESET_ADDR, 8'h00, first fetch address after reset

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-low reset
pc_load  in  1  redirect pulse from the core (branch taken / restart)
pc_in  in  8  redirect target; bit 0 ignored (forced even)
rom_rd  out  1  ROM read strobe
rom_addr  out  8  ROM byte address
rom_data  in  8  ROM read data, valid exactly 1 cycle after rom_rd
instr_valid  out  1  FIFO head holds a complete instruction
instr_ready  in  1  core accepts head this cycle
opcode1  out  8  head byte at even address
opcode2  out  8  head byte at odd address
instr_addr  out  8  address of opcode1 of head
busy  out  1  fetch engine has a read in flight

Behaviour:
- Reset (reset=0, async):
  - FIFO emptied; instr_valid=0; opcode1/opcode2/instr_addr=0.
  - rom_rd=0, rom_addr=0, busy=0.
  - fptr=RESET_ADDR; state=IDLE.
  - First posedge after release: IDLE->RD0.
- FSM states: IDLE, RD0, RD1, WAIT.
  - RD0: rom_rd=1, rom_addr=fptr; next RD1.
  - RD1: capture rom_data into hi_byte; rom_rd=1, rom_addr=fptr+1 (mod 256); set lo_pending; next RD0 if room, else WAIT.
- lo_pending cycle: the cycle after RD1, regardless of state.
  - Push {hi_byte, rom_data, fptr} into FIFO.
  - fptr<=fptr+2 (mod 256).
  - Clear lo_pending.
- Room rule: RD0 may be entered only if count + inflight < DEPTH.
  - inflight = 1 from RD0 entry until push, else 0.
  - count is post-pop for the current cycle, so a simultaneous pop frees room in the same cycle.
  - The FIFO can never overflow.
- WAIT: rom_rd=0; ->RD0 on the first cycle the room rule holds.
- Throughput: 1 instruction per 2 cycles when unstalled.
  - Latency from RD0 issue to instr_valid: 3 cycles (RD0, RD1, push, visible next cycle).
- Handshake:
  - Pop on instr_valid & instr_ready.
  - Head outputs stable while instr_valid=1 and not popped.
  - instr_ready while instr_valid=0 is ignored.
- busy=1 in RD0, RD1, and any lo_pending cycle.
- pc_load (highest priority, synchronous):
  - Clear FIFO, including any pop that cycle.
  - Discard hi_byte and lo_pending; the in-flight ROM byte arriving next cycle is dropped.
  - fptr<={pc_in[7:1],1'b0}; state<=RD0.
  - instr_valid=0 the cycle after pc_load.
  - Sequential pc_load pulses each restart fetch; the last one wins.
- Simultaneous push and pop: both occur; count unchanged.
- Wrap-around: fptr=8'hFE fetches FE, FF, then next instruction at 00. No error flag.
- Reset asserted mid-fetch: everything returns to reset values immediately; no partial instruction survives.

Test Plan:
- Reset release, ROM[0..5]=10,2A,20,3B,81,4C, instr_ready=1 -> rom_addr sequence 00,01,02,03,04,05; instr_valid pulses deliver (10,2A,@00), (20,3B,@02), (81,4C,@04); first instr_valid 3 cycles after first rom_rd.
- instr_ready=0 held, DEPTH=2 -> exactly 2 instructions buffered; rom_rd stays 0 in WAIT; head held at (10,2A,@00). Raise ready one cycle -> one pop, fetch resumes at 04 that same cycle.
- pc_load with pc_in=8'h41 during RD1 -> in-flight byte dropped, FIFO cleared, next rom_addr=40 then 41; next delivered instr_addr=40.
- pc_load with pc_in=8'hFE -> fetches FE, FF, 00, 01; instructions @FE then @00 delivered in order.
- Reset pulled low for 1 cycle while lo_pending with FIFO holding 1 entry -> instr_valid=0 immediately; after release, fetch restarts at RESET_ADDR with no stale entry delivered.
- Pop and push in the same cycle with count=DEPTH-1 -> count unchanged, order preserved, no entry lost or duplicated.
